// File: rtl/jtkcpu_pshpul_pkg.sv
// Shared definitions for the JTKCPU push/pull sequencer: FSM encodings,
// post-byte mask bit positions and the set of 16-bit registers.
package jtkcpu_pshpul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PSH_DEC = 3'd1,
    ST_PSH_WR  = 3'd2,
    ST_PUL_RD  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int unsigned BIT_CC = 0;
  localparam int unsigned BIT_A  = 1;
  localparam int unsigned BIT_B  = 2;
  localparam int unsigned BIT_DP = 3;
  localparam int unsigned BIT_X  = 4;
  localparam int unsigned BIT_Y  = 5;
  localparam int unsigned BIT_US = 6;
  localparam int unsigned BIT_PC = 7;

  localparam logic [7:0] WIDE_MASK = 8'hF0;

  function automatic logic is_wide(input logic [7:0] sel);
    return |(sel & WIDE_MASK);
  endfunction

endpackage

// File: rtl/jtkcpu_pshpul_if.sv
// Control/strobe bundle between the stack sequencer, its instruction
// decoder (master side) and the register file / memory strobes.
interface jtkcpu_pshpul_if;
  logic       cen;
  logic       start_psh;
  logic       start_pul;
  logic       ussel;
  logic [7:0] mask;
  logic       mem_ok;
  logic       busy;
  logic       done;
  logic [7:0] psh_sel;
  logic       psh_hilon;
  logic       psh_ussel;
  logic       dec_us;
  logic       pul_en;
  logic       mem_we;
  logic       mem_rd;

  modport master (
    output cen, start_psh, start_pul, ussel, mask, mem_ok,
    input  busy, done, psh_sel, psh_hilon, psh_ussel, dec_us, pul_en,
           mem_we, mem_rd
  );

  modport slave (
    input  cen, start_psh, start_pul, ussel, mask, mem_ok,
    output busy, done, psh_sel, psh_hilon, psh_ussel, dec_us, pul_en,
           mem_we, mem_rd
  );
endinterface

// File: rtl/jtkcpu_pshpul_pri.sv
// One-hot priority encoder: dir_i=1 picks the highest set bit, dir_i=0 the
// lowest. All-zero request gives an all-zero grant.
module jtkcpu_pshpul_pri (
  input  logic [7:0] req_i,
  input  logic       dir_i,
  output logic [7:0] gnt_o
);

  logic       found;
  logic [2:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 8; i++) begin
      idx = dir_i ? 3'(7 - i) : 3'(i);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtkcpu_pshpul.sv
// Stack push/pull sequencer: walks the post-byte mask one byte per bus
// access and drives register-file selects plus memory strobes.
module jtkcpu_pshpul
  import jtkcpu_pshpul_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  jtkcpu_pshpul_if.slave     bus
);

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic       byte_q, byte_d;   // 1 once the first byte of a wide register is done
  logic       ussel_q, ussel_d;

  logic [7:0] sel;
  logic [7:0] pend_clr;
  logic       active;
  logic       is_push;
  logic       wide;
  logic       last_byte;

  // Push walks from the top of the mask, pull from the bottom.
  jtkcpu_pshpul_pri u_pri (
    .req_i (pend_q),
    .dir_i (is_push),
    .gnt_o (sel)
  );

  assign is_push   = (state_q != ST_PUL_RD);
  assign active    = (state_q == ST_PSH_DEC) || (state_q == ST_PSH_WR) ||
                     (state_q == ST_PUL_RD);
  assign wide      = is_wide(sel);
  assign last_byte = !wide || byte_q;
  assign pend_clr  = pend_q & ~sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      byte_q  <= 1'b0;
      ussel_q <= 1'b0;
    end else if (bus.cen) begin
      state_q <= state_d;
      pend_q  <= pend_d;
      byte_q  <= byte_d;
      ussel_q <= ussel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    byte_d     = byte_q;
    ussel_d    = ussel_q;
    bus.done   = 1'b0;
    bus.dec_us = 1'b0;
    bus.pul_en = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_rd = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_psh || bus.start_pul) begin
          pend_d  = bus.mask;
          ussel_d = bus.ussel;
          byte_d  = 1'b0;
          if (bus.mask == 8'h00)  state_d = ST_DONE;
          else if (bus.start_psh) state_d = ST_PSH_DEC;
          else                    state_d = ST_PUL_RD;
        end
      end
      ST_PSH_DEC: begin
        bus.dec_us = bus.cen;
        state_d    = ST_PSH_WR;
      end
      ST_PSH_WR: begin
        bus.mem_we = bus.cen;
        if (bus.mem_ok) begin
          if (last_byte) begin
            pend_d = pend_clr;
            byte_d = 1'b0;
          end else begin
            byte_d = 1'b1;
          end
          state_d = (last_byte && pend_clr == 8'h00) ? ST_DONE : ST_PSH_DEC;
        end
      end
      ST_PUL_RD: begin
        bus.mem_rd = bus.cen;
        if (bus.mem_ok) begin
          bus.pul_en = bus.cen;
          if (last_byte) begin
            pend_d = pend_clr;
            byte_d = 1'b0;
          end else begin
            byte_d = 1'b1;
          end
          if (last_byte && pend_clr == 8'h00) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Push sends low byte first, pull receives high byte first.
  assign bus.busy      = active;
  assign bus.psh_sel   = active ? sel : 8'h00;
  assign bus.psh_hilon = active && (is_push ? byte_q : (wide && !byte_q));
  assign bus.psh_ussel = ussel_q;

endmodule
